// File: rtl/multi_channel_watchdog_pkg.sv
// Shared types and limits for the N-channel watchdog.
// Optional half-time warning output is enabled by MULTI_CHANNEL_WATCHDOG_WARN_EN.
package multi_channel_watchdog_pkg;

    typedef enum logic [1:0] {
        WD_IDLE,
        WD_ARMED,
        WD_EXPIRED
    } wd_state_t;

    localparam int WD_MAX_CH = 32;

endpackage

// File: rtl/multi_channel_watchdog_channel.sv
// One watchdog channel: IDLE/ARMED/EXPIRED FSM with a reloadable down-counter.
// MULTI_CHANNEL_WATCHDOG_WARN_EN adds a latched timeout and the warn output.
module watchdog_channel
    import multi_channel_watchdog_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 arm,
    input  logic                 kick,
    input  logic                 disarm,
    input  logic                 clr,
    input  logic [CNT_WIDTH-1:0] timeout,
    output logic                 armed,
    output logic                 expired,
    output logic                 expired_pulse
`ifdef MULTI_CHANNEL_WATCHDOG_WARN_EN
    ,
    output logic                 warn
`endif
);

    wd_state_t            state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 pulse_q, pulse_d;

`ifdef MULTI_CHANNEL_WATCHDOG_WARN_EN
    logic [CNT_WIDTH-1:0] tlat_q, tlat_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
`ifdef MULTI_CHANNEL_WATCHDOG_WARN_EN
        tlat_d  = tlat_q;
`endif
        unique case (state_q)
            WD_IDLE: begin
                if (!disarm && arm) begin
                    state_d = WD_ARMED;
                    cnt_d   = timeout;
`ifdef MULTI_CHANNEL_WATCHDOG_WARN_EN
                    tlat_d  = timeout;
`endif
                end
            end
            WD_ARMED: begin
                // Reload beats the tick, so a kick on the last tick saves the channel.
                if (disarm) begin
                    state_d = WD_IDLE;
                    cnt_d   = '0;
                end else if (arm || kick) begin
                    cnt_d   = timeout;
`ifdef MULTI_CHANNEL_WATCHDOG_WARN_EN
                    tlat_d  = timeout;
`endif
                end else if (tick) begin
                    if (cnt_q <= CNT_WIDTH'(1)) begin
                        state_d = WD_EXPIRED;
                        cnt_d   = '0;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_WIDTH'(1);
                    end
                end
            end
            WD_EXPIRED: begin
                cnt_d = '0;
                if (disarm || clr) begin
                    state_d = WD_IDLE;
                end
            end
            default: begin
                state_d = WD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WD_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

`ifdef MULTI_CHANNEL_WATCHDOG_WARN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tlat_q <= '0;
        end else begin
            tlat_q <= tlat_d;
        end
    end

    assign warn = (state_q == WD_ARMED) && (cnt_q <= (tlat_q >> 1));
`endif

    assign armed         = (state_q == WD_ARMED);
    assign expired       = (state_q == WD_EXPIRED);
    assign expired_pulse = pulse_q;

endmodule

// File: rtl/multi_channel_watchdog.sv
// N-channel watchdog top: shared tick prescaler, channel array, any_expired.
// MULTI_CHANNEL_WATCHDOG_WARN_EN adds the per-channel warn output.
module multi_channel_watchdog
    import multi_channel_watchdog_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int CNT_WIDTH = 16,
    parameter int PRESCALE  = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_CH-1:0]           arm,
    input  logic [N_CH-1:0]           kick,
    input  logic [N_CH-1:0]           disarm,
    input  logic [N_CH-1:0]           clr_expired,
    input  logic [N_CH*CNT_WIDTH-1:0] timeout_cfg,
    output logic [N_CH-1:0]           armed,
    output logic [N_CH-1:0]           expired,
    output logic [N_CH-1:0]           expired_pulse,
    output logic                      any_expired
`ifdef MULTI_CHANNEL_WATCHDOG_WARN_EN
    ,
    output logic [N_CH-1:0]           warn
`endif
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pre_q, pre_d;
    logic          tick;

    assign tick = (pre_q == PW'(PRESCALE - 1));

    always_comb begin
        pre_d = tick ? '0 : pre_q + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        watchdog_channel #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .tick         (tick),
            .arm          (arm[ch]),
            .kick         (kick[ch]),
            .disarm       (disarm[ch]),
            .clr          (clr_expired[ch]),
            .timeout      (timeout_cfg[ch*CNT_WIDTH +: CNT_WIDTH]),
            .armed        (armed[ch]),
            .expired      (expired[ch]),
            .expired_pulse(expired_pulse[ch])
`ifdef MULTI_CHANNEL_WATCHDOG_WARN_EN
            ,
            .warn         (warn[ch])
`endif
        );
    end

    assign any_expired = |expired;

endmodule

// File: tb/tb_multi_channel_watchdog.sv
// Directed bench: one PRESCALE=1 instance and one PRESCALE=4 instance.
// Warn checks run only when MULTI_CHANNEL_WATCHDOG_WARN_EN is defined.
module tb_multi_channel_watchdog;

    logic        clk;
    logic        rst_n;
    logic [3:0]  arm, kick, disarm, clr;
    logic [31:0] cfg;
    logic [3:0]  armed, expired, pulse;
    logic        any_exp;

    logic [3:0]  p_arm, p_kick, p_disarm, p_clr;
    logic [31:0] p_cfg;
    logic [3:0]  p_armed, p_expired, p_pulse;
    logic        p_any;

`ifdef MULTI_CHANNEL_WATCHDOG_WARN_EN
    logic [3:0]  warn, p_warn;
`endif

    int vectors;
    int errors;

    multi_channel_watchdog #(
        .N_CH(4), .CNT_WIDTH(8), .PRESCALE(1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arm          (arm),
        .kick         (kick),
        .disarm       (disarm),
        .clr_expired  (clr),
        .timeout_cfg  (cfg),
        .armed        (armed),
        .expired      (expired),
        .expired_pulse(pulse),
        .any_expired  (any_exp)
`ifdef MULTI_CHANNEL_WATCHDOG_WARN_EN
        ,
        .warn         (warn)
`endif
    );

    multi_channel_watchdog #(
        .N_CH(4), .CNT_WIDTH(8), .PRESCALE(4)
    ) dut_p4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .arm          (p_arm),
        .kick         (p_kick),
        .disarm       (p_disarm),
        .clr_expired  (p_clr),
        .timeout_cfg  (p_cfg),
        .armed        (p_armed),
        .expired      (p_expired),
        .expired_pulse(p_pulse),
        .any_expired  (p_any)
`ifdef MULTI_CHANNEL_WATCHDOG_WARN_EN
        ,
        .warn         (p_warn)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        arm = '0; kick = '0; disarm = '0; clr = '0;
        p_arm = '0; p_kick = '0; p_disarm = '0; p_clr = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_all();
        cfg = '0;
        p_cfg = '0;
        #12;
        vectors++;
        if ({armed, expired, pulse, any_exp} !== 13'h0) begin
            $display("FAIL reset_outputs: got %h expected 0",
                     {armed, expired, pulse, any_exp});
            errors++;
        end
        vectors++;
        if ({p_armed, p_expired, p_pulse, p_any} !== 13'h0) begin
            $display("FAIL reset_outputs_p4: got %h expected 0",
                     {p_armed, p_expired, p_pulse, p_any});
            errors++;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_expiry();
        cfg[7:0] = 8'd5;
        arm[0] = 1'b1;
        step();
        arm[0] = 1'b0;
        vectors++;
        if (armed[0] !== 1'b1 || expired[0] !== 1'b0) begin
            $display("FAIL exp_armed: got armed=%b expired=%b expected 1 0",
                     armed[0], expired[0]);
            errors++;
        end
        for (int i = 1; i <= 5; i++) begin
            step();
            vectors++;
            if (expired[0] !== (i == 5) || pulse[0] !== (i == 5)) begin
                $display("FAIL exp_t5 cyc%0d: got exp=%b pulse=%b expected %b",
                         i, expired[0], pulse[0], (i == 5));
                errors++;
            end
        end
        vectors++;
        if (any_exp !== 1'b1 || armed[0] !== 1'b0) begin
            $display("FAIL exp_any: got any=%b armed=%b expected 1 0",
                     any_exp, armed[0]);
            errors++;
        end
        step();
        vectors++;
        if (pulse[0] !== 1'b0 || expired[0] !== 1'b1) begin
            $display("FAIL exp_sticky: got pulse=%b exp=%b expected 0 1",
                     pulse[0], expired[0]);
            errors++;
        end
        clr[0] = 1'b1;
        step();
        clr[0] = 1'b0;
        vectors++;
        if (expired[0] !== 1'b0 || any_exp !== 1'b0 || armed[0] !== 1'b0) begin
            $display("FAIL exp_clr: got exp=%b any=%b armed=%b expected 0 0 0",
                     expired[0], any_exp, armed[0]);
            errors++;
        end
    endtask

    task automatic test_kick();
        int bad;
        cfg[15:8] = 8'd4;
        arm[1] = 1'b1;
        step();
        arm[1] = 1'b0;
        bad = 0;
        for (int j = 1; j <= 21; j++) begin
            kick[1] = (j % 3 == 0);
            step();
            kick[1] = 1'b0;
            if (expired[1] !== 1'b0 || armed[1] !== 1'b1) bad++;
        end
        vectors++;
        if (bad != 0) begin
            $display("FAIL kick_keepalive: got %0d bad cycles expected 0", bad);
            errors++;
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            vectors++;
            if (expired[1] !== (i == 4)) begin
                $display("FAIL kick_lapse cyc%0d: got %b expected %b",
                         i, expired[1], (i == 4));
                errors++;
            end
        end
        clr[1] = 1'b1;
        step();
        clr[1] = 1'b0;
    endtask

    task automatic test_priority();
        cfg[23:16] = 8'd1;
        arm[2] = 1'b1;
        step();
        arm[2] = 1'b0;
        disarm[2] = 1'b1;
        kick[2] = 1'b1;
        step();
        disarm[2] = 1'b0;
        kick[2] = 1'b0;
        vectors++;
        if ({armed[2], expired[2], pulse[2]} !== 3'b000) begin
            $display("FAIL prio_disarm: got %b expected 000",
                     {armed[2], expired[2], pulse[2]});
            errors++;
        end
        arm[2] = 1'b1;
        step();
        arm[2] = 1'b0;
        step();
        vectors++;
        if (expired[2] !== 1'b1) begin
            $display("FAIL prio_t1: got %b expected 1", expired[2]);
            errors++;
        end
        arm[2] = 1'b1;
        kick[2] = 1'b1;
        step();
        step();
        arm[2] = 1'b0;
        kick[2] = 1'b0;
        vectors++;
        if (expired[2] !== 1'b1 || armed[2] !== 1'b0) begin
            $display("FAIL prio_arm_exp: got exp=%b armed=%b expected 1 0",
                     expired[2], armed[2]);
            errors++;
        end
        clr[2] = 1'b1;
        step();
        clr[2] = 1'b0;
        vectors++;
        if (expired[2] !== 1'b0 || armed[2] !== 1'b0) begin
            $display("FAIL prio_clr: got exp=%b armed=%b expected 0 0",
                     expired[2], armed[2]);
            errors++;
        end
    endtask

    task automatic test_cfg_hold();
        cfg[7:0] = 8'd3;
        arm[0] = 1'b1;
        step();
        arm[0] = 1'b0;
        cfg[7:0] = 8'd100;
        step();
        step();
        vectors++;
        if (expired[0] !== 1'b0) begin
            $display("FAIL cfg_hold_early: got %b expected 0", expired[0]);
            errors++;
        end
        step();
        vectors++;
        if (expired[0] !== 1'b1) begin
            $display("FAIL cfg_hold: got %b expected 1", expired[0]);
            errors++;
        end
        clr[0] = 1'b1;
        step();
        clr[0] = 1'b0;
    endtask

    task automatic test_prescale();
        int n;
        p_cfg[31:24] = 8'd2;
        p_arm[3] = 1'b1;
        step();
        p_arm[3] = 1'b0;
        n = 0;
        while (p_expired[3] !== 1'b1 && n < 12) begin
            step();
            n++;
        end
        vectors++;
        if (n < 5 || n > 8) begin
            $display("FAIL ps4_t2: got %0d cycles expected 5..8", n);
            errors++;
        end
        p_clr[3] = 1'b1;
        step();
        p_clr[3] = 1'b0;
        p_cfg[31:24] = 8'd0;
        p_arm[3] = 1'b1;
        step();
        p_arm[3] = 1'b0;
        n = 0;
        while (p_expired[3] !== 1'b1 && n < 12) begin
            step();
            n++;
        end
        vectors++;
        if (n < 1 || n > 4) begin
            $display("FAIL ps4_t0: got %0d cycles expected 1..4", n);
            errors++;
        end
        p_clr[3] = 1'b1;
        step();
        p_clr[3] = 1'b0;
    endtask

    task automatic test_back_to_back();
        cfg = {4{8'd3}};
        arm = 4'hF;
        step();
        arm = 4'h0;
        for (int i = 1; i <= 3; i++) begin
            step();
            vectors++;
            if (expired !== ((i == 3) ? 4'hF : 4'h0)
                || pulse !== ((i == 3) ? 4'hF : 4'h0)) begin
                $display("FAIL all_ch cyc%0d: got exp=%h pulse=%h", i,
                         expired, pulse);
                errors++;
            end
        end
        clr = 4'hF;
        step();
        clr = 4'h0;
        cfg = {4{8'd10}};
        arm = 4'hF;
        step();
        arm = 4'h0;
        step();
        vectors++;
        if (armed !== 4'hF) begin
            $display("FAIL rst_pre: got %h expected f", armed);
            errors++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({armed, expired, pulse, any_exp} !== 13'h0) begin
            $display("FAIL async_rst: got %h expected 0",
                     {armed, expired, pulse, any_exp});
            errors++;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
    endtask

`ifdef MULTI_CHANNEL_WATCHDOG_WARN_EN
    task automatic test_warn();
        cfg[7:0] = 8'd8;
        arm[0] = 1'b1;
        step();
        arm[0] = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            vectors++;
            if (warn[0] !== (i == 4)) begin
                $display("FAIL warn_rise cyc%0d: got %b expected %b",
                         i, warn[0], (i == 4));
                errors++;
            end
        end
        kick[0] = 1'b1;
        step();
        kick[0] = 1'b0;
        vectors++;
        if (warn[0] !== 1'b0) begin
            $display("FAIL warn_kick: got %b expected 0", warn[0]);
            errors++;
        end
        disarm[0] = 1'b1;
        step();
        disarm[0] = 1'b0;
    endtask
`endif

    initial begin
        vectors = 0;
        errors = 0;
        test_reset();
        test_expiry();
        test_kick();
        test_priority();
        test_cfg_hold();
        test_prescale();
        test_back_to_back();
`ifdef MULTI_CHANNEL_WATCHDOG_WARN_EN
        test_warn();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
